// File: rtl/lstm_addr_seq.sv
// lstm_addr_seq: incremental read/write address sequencer for one LSTM matrix-vector pass
module lstm_addr_seq #(
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_CELL   = 53,
    parameter int NUM_INPUT  = 53,
    parameter int TIMESTEP   = 7,
    parameter int PAUSE_LEN  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dir,
    input  logic                  transpose,
    input  logic                  en,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] o_addr_w,
    output logic [ADDR_WIDTH-1:0] o_addr_v,
    output logic [ADDR_WIDTH-1:0] o_addr_out,
    output logic                  o_row_last,
    output logic                  o_step_last,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int MAXD = NUM_CELL > NUM_INPUT ? NUM_CELL : NUM_INPUT;
    localparam int CW   = MAXD > 1 ? $clog2(MAXD) : 1;
    localparam int TW   = TIMESTEP > 1 ? $clog2(TIMESTEP) : 1;
    localparam int PW   = PAUSE_LEN > 1 ? $clog2(PAUSE_LEN) : 1;
    localparam int PL1  = PAUSE_LEN > 0 ? PAUSE_LEN - 1 : 0;
    localparam logic [ADDR_WIDTH-1:0] NI_A    = ADDR_WIDTH'(NUM_INPUT);
    localparam logic [ADDR_WIDTH-1:0] NC_A    = ADDR_WIDTH'(NUM_CELL);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_NI = ADDR_WIDTH'((TIMESTEP - 1) * NUM_INPUT);
    localparam logic [ADDR_WIDTH-1:0] LAST_NC = ADDR_WIDTH'((TIMESTEP - 1) * NUM_CELL);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t                state, state_n;
    logic                  dir_q, dir_n, tr_q, tr_n;
    logic [CW-1:0]         c, c_n, r, r_n, c_max, c_max_n, r_max, r_max_n;
    logic [TW-1:0]         t, t_n;
    logic [PW-1:0]         p, p_n;
    logic [ADDR_WIDTH-1:0] w_row, w_row_n, v_base, v_base_n, o_base, o_base_n;
    logic [ADDR_WIDTH-1:0] aw_n, av_n, ao_n;
    logic [ADDR_WIDTH-1:0] c_len, r_len, w_cs, w_rs;
    logic                  row_end, step_end, t_end;

    // next-state and next-address computation; row/step bases are reloaded at boundaries
    always_comb begin
        c_len    = tr_q ? NC_A : NI_A;
        r_len    = tr_q ? NI_A : NC_A;
        w_cs     = tr_q ? NI_A : ONE_A;
        w_rs     = tr_q ? ONE_A : NI_A;
        row_end  = c == c_max;
        step_end = row_end && r == r_max;
        t_end    = dir_q ? t == '0 : t == TW'(TIMESTEP - 1);
        state_n  = state;
        dir_n    = dir_q;
        tr_n     = tr_q;
        c_n      = c;
        r_n      = r;
        t_n      = t;
        p_n      = p;
        c_max_n  = c_max;
        r_max_n  = r_max;
        w_row_n  = w_row;
        v_base_n = v_base;
        o_base_n = o_base;
        aw_n     = o_addr_w;
        av_n     = o_addr_v;
        ao_n     = o_addr_out;
        case (state)
            IDLE: if (start) begin
                state_n  = RUN;
                dir_n    = dir;
                tr_n     = transpose;
                c_max_n  = transpose ? CW'(NUM_CELL - 1) : CW'(NUM_INPUT - 1);
                r_max_n  = transpose ? CW'(NUM_INPUT - 1) : CW'(NUM_CELL - 1);
                c_n      = '0;
                r_n      = '0;
                p_n      = '0;
                t_n      = dir ? TW'(TIMESTEP - 1) : '0;
                v_base_n = dir ? (transpose ? LAST_NC : LAST_NI) : '0;
                o_base_n = dir ? (transpose ? LAST_NI : LAST_NC) : '0;
                w_row_n  = '0;
                aw_n     = '0;
                av_n     = v_base_n;
                ao_n     = o_base_n;
            end
            RUN: if (!row_end) begin
                c_n  = c + CW'(1);
                aw_n = o_addr_w + w_cs;
                av_n = o_addr_v + ONE_A;
            end else if (step_end && t_end) begin
                state_n = DONE;
            end else begin
                c_n = '0;
                if (step_end) begin
                    r_n      = '0;
                    t_n      = dir_q ? t - TW'(1) : t + TW'(1);
                    v_base_n = dir_q ? v_base - c_len : v_base + c_len;
                    o_base_n = dir_q ? o_base - r_len : o_base + r_len;
                    w_row_n  = '0;
                    ao_n     = o_base_n;
                end else begin
                    r_n     = r + CW'(1);
                    w_row_n = w_row + w_rs;
                    ao_n    = o_addr_out + ONE_A;
                end
                aw_n    = w_row_n;
                av_n    = v_base_n;
                p_n     = '0;
                state_n = PAUSE_LEN > 0 ? PAUSE : RUN;
            end
            PAUSE: if (p == PW'(PL1)) state_n = RUN;
                   else p_n = p + PW'(1);
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // state, counters and registered outputs; en=0 holds everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dir_q       <= 1'b0;
            tr_q        <= 1'b0;
            c           <= '0;
            r           <= '0;
            t           <= '0;
            p           <= '0;
            c_max       <= '0;
            r_max       <= '0;
            w_row       <= '0;
            v_base      <= '0;
            o_base      <= '0;
            o_valid     <= 1'b0;
            o_addr_w    <= '0;
            o_addr_v    <= '0;
            o_addr_out  <= '0;
            o_row_last  <= 1'b0;
            o_step_last <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else if (en) begin
            state       <= state_n;
            dir_q       <= dir_n;
            tr_q        <= tr_n;
            c           <= c_n;
            r           <= r_n;
            t           <= t_n;
            p           <= p_n;
            c_max       <= c_max_n;
            r_max       <= r_max_n;
            w_row       <= w_row_n;
            v_base      <= v_base_n;
            o_base      <= o_base_n;
            o_valid     <= state_n == RUN;
            o_addr_w    <= aw_n;
            o_addr_v    <= av_n;
            o_addr_out  <= ao_n;
            o_row_last  <= state_n == RUN && c_n == c_max_n;
            o_step_last <= state_n == RUN && c_n == c_max_n && r_n == r_max_n;
            o_busy      <= state_n == RUN || state_n == PAUSE;
            o_done      <= state_n == DONE;
        end
    end
endmodule
